tb_uart_rx: RTL and testbench
=============================

# tb_uart_rx

Synthesizable-style UART 8N1 receiver for the Occamy simulation testharness. It consumes the `uart_tx_o` line of `occamy_top` and recovers the transmitted bytes using a per-bit clock counter. Recovered bytes go into a show-ahead FIFO that a testbench consumer (console printer, scoreboard) drains through a valid/ready handshake. It runs next to the DPI UART model and is clocked from the same clock as the DUT.

## Interface
- `FREQ`, 1_000_000: system clock frequency in Hz.
- `BAUD`, 125_000: line baud rate. `ClksPerBit = FREQ/BAUD` uses integer division.
  - Elaboration fails with `$fatal` if `ClksPerBit < 4`.
- `FifoDepth`, 16: FIFO entries. Must be a power of two and at least 2; otherwise elaboration fails with `$fatal`.

- `clk_i`, in, 1: the single clock.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `rx_i`, in, 1: serial line, asynchronous to `clk_i`. Idle level is 1.
- `data_o`, out, 8: byte at the FIFO head.
- `valid_o`, out, 1: FIFO is non-empty.
- `ready_i`, in, 1: consumer accepts `data_o`.
- `count_o`, out, `$clog2(FifoDepth+1)`: FIFO fill level.
- `busy_o`, out, 1: receiver FSM is not IDLE.
- `frame_err_o`, out, 1: sticky flag, set when a stop bit is sampled as 0.
- `overflow_o`, out, 1: sticky flag, set when a byte is dropped because the FIFO is full.
- `clear_i`, in, 1: clears both sticky flags.

## Operation
- **Input synchronizer.** `rx_i` passes through a 2-flop synchronizer with reset value 1, giving `rx_s`. A delayed copy `rx_q` (reset value 1) is used for edge detection.
- **FSM states:** IDLE, START, DATA, STOP. A counter `cnt` runs from 0 to `ClksPerBit-1`, and a 3-bit counter `bit_idx` indexes data bits.
- **IDLE.**
  - A falling edge (`rx_q==1 && rx_s==0`) moves the FSM to START and sets `cnt=0`.
  - A line held low never re-triggers a frame; a new falling edge is required.
- **START.** At `cnt == ClksPerBit/2 - 1` the FSM samples `rx_s`.
  - If 0: go to DATA with `cnt=0`, `bit_idx=0`.
  - If 1: treat as a glitch and return to IDLE. No flag is set.
- **DATA.** At `cnt == ClksPerBit-1` the FSM samples `rx_s` into the shift register, LSB first.
  - The sample for `bit_idx==7` moves the FSM to STOP. Otherwise `bit_idx` increments.
- **STOP.** At `cnt == ClksPerBit-1` the FSM samples `rx_s` and returns to IDLE.
  - Sample 1: push the byte to the FIFO.
  - Sample 0: discard the byte and set `frame_err_o`.
- **FIFO.** Show-ahead: `data_o` is the head entry and is 0 when the FIFO is empty.
  - Pop happens when `valid_o && ready_i`.
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow_o` is set.
  - Read and write pointers wrap modulo `FifoDepth`. Fullness is tracked with one extra pointer bit.
- **Sticky flags.** Both flags clear on `clear_i`. If a set event and `clear_i` occur in the same cycle, the set wins.
- **Reset.** Reset mid-frame aborts the frame: the FSM returns to IDLE and the FIFO is emptied.

## Timing
- Reset values of all outputs:
  - `data_o` = 0, `valid_o` = 0, `count_o` = 0, `busy_o` = 0, `frame_err_o` = 0, `overflow_o` = 0.
  - Internal state: FSM in IDLE, synchronizer flops at 1.
- Let E be the cycle in which the falling edge is detected, i.e. the START transition registers at the end of cycle E. Edge detection happens 2–3 clocks after `rx_i` falls (synchronizer delay).
- Sampling points, counted from E:
  - Start bit: E + `ClksPerBit/2`.
  - Data bit k: E + `ClksPerBit/2` + (k+1)·`ClksPerBit`.
  - Stop bit: E + `ClksPerBit/2` + 9·`ClksPerBit`.
- After the stop-bit sample:
  - The push is registered in the sample cycle.
  - `valid_o` and `count_o` update in the next cycle.
  - `frame_err_o` updates in the next cycle.
- `busy_o` is high from E+1 through the stop-sample cycle.
- A pop updates `count_o` and `data_o` in the next cycle. At most one pop per cycle.
- Back-to-back frames are supported: a falling edge in the cycle after STOP returns to IDLE starts the next frame. The stop sample falls in mid-bit, which leaves half a bit time of margin.

## Test plan
All scenarios use `FREQ`=1_000_000 and `BAUD`=125_000 (8 clocks/bit).

1. **Single frame.**
   - Stimulus: drive 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with `ready_i`=0.
   - Required response: `valid_o`=1, `data_o`=0xA5, `count_o`=1, no flags. After one `ready_i` pulse, `valid_o`=0.
2. **Glitch rejection.**
   - Stimulus: a 2-clock low pulse on an idle line.
   - Required response: `busy_o` pulses, then returns to 0. `count_o`=0, `frame_err_o`=0.
3. **Framing error.**
   - Stimulus: byte 0x3C with stop bit driven 0, then the line returns to 1, then byte 0x11.
   - Required response: `frame_err_o`=1, and only 0x11 is in the FIFO. `clear_i` then drops `frame_err_o` to 0.
4. **Overflow.**
   - Stimulus: 17 back-to-back bytes 0x00..0x10 with `ready_i`=0.
   - Required response: `count_o`=16, `overflow_o`=1. Draining yields 0x00..0x0F in order.
5. **Full with same-cycle pop and push.**
   - Stimulus: FIFO full, and `ready_i`=1 in exactly the stop-sample cycle of byte 0x77.
   - Required response: no overflow, `count_o` stays 16, and 0x77 is the last byte drained.
6. **Reset mid-frame.**
   - Stimulus: assert `rst_ni`=0 during data bit 4, release it, then send 0x5A.
   - Required response: all outputs are at reset values during reset, and 0x5A is received correctly afterwards.

Source files
------------

// File: rtl/tb_uart_rx.sv
// UART 8N1 receiver: synchronised line, mid-bit sampling, show-ahead byte FIFO drained by valid/ready.
// Byte visible one clock after its stop-bit sample; a byte arriving at a full FIFO with no pop is dropped and flagged.
module tb_uart_rx #(
  parameter int unsigned FREQ      = 1_000_000,
  parameter int unsigned BAUD      = 125_000,
  parameter int unsigned FifoDepth = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             rx_i,
  output logic [7:0]                       data_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [$clog2(FifoDepth+1)-1:0]   count_o,
  output logic                             busy_o,
  output logic                             frame_err_o,
  output logic                             overflow_o,
  input  logic                             clear_i
);
  localparam int unsigned ClksPerBit = FREQ / BAUD;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam int unsigned AddrW      = $clog2(FifoDepth);
  localparam int unsigned CountW     = $clog2(FifoDepth + 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

  if (ClksPerBit < 4) begin : g_bad_baud
    $fatal(1, "tb_uart_rx: FREQ/BAUD must be at least 4");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $fatal(1, "tb_uart_rx: FifoDepth must be a power of two >= 2");
  end

  // Line synchroniser plus one extra stage for falling-edge detection; idle level is 1.
  logic rx_meta, rx_s, rx_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            push, ferr_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_q && !rx_s) state_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_q == CntHalf) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CntLast) begin
          cnt_d    = '0;
          state_d  = IDLE;
          push     = rx_s;
          ferr_set = !rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  // Byte FIFO; pointers carry one wrap bit so full and empty are distinguishable.
  logic [7:0]     mem [FifoDepth];
  logic [AddrW:0] wr_ptr_q, rd_ptr_q;
  logic           empty, full, pop, wr_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign pop   = !empty && ready_i;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q[AddrW-1:0]] <= shreg_q;
  end

  assign valid_o = !empty;
  assign data_o  = empty ? 8'h00 : mem[rd_ptr_q[AddrW-1:0]];
  assign count_o = CountW'(wr_ptr_q - rd_ptr_q);

  // Sticky flags: a set event in the same cycle as clear_i wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      frame_err_o <= ferr_set | (frame_err_o & ~clear_i);
      overflow_o  <= (push & full & ~pop) | (overflow_o & ~clear_i);
    end
  end

endmodule

// File: tb/tb_tb_uart_rx.sv
// Bench for tb_uart_rx: directed frames, with an event-level model (expected bytes, flags and busy windows)
// compared against the outputs every cycle, plus literal expectations per scenario.
module tb_tb_uart_rx;
  localparam int Depth = 16;

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic       rx_i    = 1'b1;
  logic       ready_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic [4:0] count_o;
  logic       busy_o;
  logic       frame_err_o;
  logic       overflow_o;

  tb_uart_rx #(.FREQ(1_000_000), .BAUD(125_000), .FifoDepth(Depth)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .count_o     (count_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o),
    .clear_i     (clear_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a frame whose start is driven in cycle n is stop-sampled in cycle n+78
  // (2 synchroniser clocks, half a bit to the start sample, then 9 full bits).
  typedef struct {int cyc; bit ok; logic [7:0] dat;} ev_t;
  typedef struct {int lo; int hi;} win_t;

  ev_t        ev_q[$];
  win_t       win_q[$];
  logic [7:0] m_fifo[$];
  bit         m_ferr = 1'b0;
  bit         m_ovf  = 1'b0;
  bit         f_set, o_set;

  initial forever begin
    @(posedge clk_i or negedge rst_ni);
    if (!rst_ni) begin
      m_fifo.delete();
      ev_q.delete();
      win_q.delete();
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      f_set = 1'b0;
      o_set = 1'b0;
      if (m_fifo.size() != 0 && ready_i) void'(m_fifo.pop_front());
      if (ev_q.size() != 0 && ev_q[0].cyc == cyc) begin
        if (!ev_q[0].ok)            f_set = 1'b1;
        else if (m_fifo.size() < Depth) m_fifo.push_back(ev_q[0].dat);
        else                        o_set = 1'b1;
        void'(ev_q.pop_front());
      end
      m_ferr = f_set | (m_ferr & ~clear_i);
      m_ovf  = o_set | (m_ovf & ~clear_i);
    end
  end

  bit         b_exp;
  logic [7:0] h_exp;
  initial forever begin
    @(negedge clk_i);
    if (chk_en) begin
      b_exp = 1'b0;
      foreach (win_q[i]) if (cyc >= win_q[i].lo && cyc <= win_q[i].hi) b_exp = 1'b1;
      h_exp = (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
      check("m_valid", 32'(valid_o), 32'(m_fifo.size() != 0));
      check("m_data",  32'(data_o), 32'(h_exp));
      check("m_count", 32'(count_o), 32'(m_fifo.size()));
      check("m_busy",  32'(busy_o), 32'(b_exp));
      check("m_ferr",  32'(frame_err_o), 32'(m_ferr));
      check("m_ovf",   32'(overflow_o), 32'(m_ovf));
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    int n;
    n = cyc;
    ev_q.push_back('{cyc: n + 78, ok: stop, dat: b});
    win_q.push_back('{lo: n + 3, hi: n + 78});
    rx_i = 1'b0;
    tick(8);
    for (int k = 0; k < 8; k++) begin
      rx_i = b[k];
      tick(8);
    end
    rx_i = stop;
    tick(8);
  endtask

  task automatic drain_expect(input logic [7:0] exp);
    check("drain_valid", 32'(valid_o), 32'd1);
    check("drain_data", 32'(data_o), 32'(exp));
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_data"},  32'(data_o), 32'd0);
    check({tag, "_count"}, 32'(count_o), 32'd0);
    check({tag, "_busy"},  32'(busy_o), 32'd0);
    check({tag, "_ferr"},  32'(frame_err_o), 32'd0);
    check({tag, "_ovf"},   32'(overflow_o), 32'd0);
  endtask

  bit         seen;
  int         n0;
  logic [7:0] pb;

  initial begin
    tick(3);
    chk_en = 1'b1;
    check_reset_vals("rst0");
    rst_ni = 1'b1;
    tick(4);

    // Single frame
    send_byte(8'hA5, 1'b1);
    check("s1_valid", 32'(valid_o), 32'd1);
    check("s1_data", 32'(data_o), 32'hA5);
    check("s1_count", 32'(count_o), 32'd1);
    check("s1_flags", 32'({frame_err_o, overflow_o}), 32'd0);
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    check("s1_popped", 32'(valid_o), 32'd0);
    tick(4);

    // Two-clock glitch: edge seen in n+2, start sample in n+6 reads high
    n0 = cyc;
    win_q.push_back('{lo: n0 + 3, hi: n0 + 6});
    rx_i = 1'b0;
    tick(2);
    rx_i = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick(1);
      if (busy_o) seen = 1'b1;
    end
    check("s2_busy_seen", 32'(seen), 32'd1);
    check("s2_busy_end", 32'(busy_o), 32'd0);
    check("s2_count", 32'(count_o), 32'd0);
    check("s2_ferr", 32'(frame_err_o), 32'd0);

    // Framing error then a good byte
    send_byte(8'h3C, 1'b0);
    rx_i = 1'b1;
    tick(4);
    send_byte(8'h11, 1'b1);
    tick(2);
    check("s3_ferr", 32'(frame_err_o), 32'd1);
    check("s3_count", 32'(count_o), 32'd1);
    check("s3_data", 32'(data_o), 32'h11);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    check("s3_ferr_clr", 32'(frame_err_o), 32'd0);
    drain_expect(8'h11);

    // Overflow: 17 back-to-back bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
    tick(2);
    check("s4_count", 32'(count_o), 32'd16);
    check("s4_ovf", 32'(overflow_o), 32'd1);
    for (int i = 0; i < 16; i++) drain_expect(8'(i));
    check("s4_empty", 32'(valid_o), 32'd0);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    check("s4_ovf_clr", 32'(overflow_o), 32'd0);

    // Full FIFO with a pop in exactly the stop-sample cycle of 0x77
    for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i), 1'b1);
    fork
      send_byte(8'h77, 1'b1);
      begin
        tick(78);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
      end
    join
    tick(2);
    check("s5_count", 32'(count_o), 32'd16);
    check("s5_ovf", 32'(overflow_o), 32'd0);
    for (int i = 1; i < 16; i++) drain_expect(8'h60 + 8'(i));
    drain_expect(8'h77);
    check("s5_empty", 32'(valid_o), 32'd0);

    // Reset in the middle of data bit 4, with state to lose beforehand
    send_byte(8'h42, 1'b1);
    send_byte(8'h3C, 1'b0);
    rx_i = 1'b1;
    tick(4);
    check("s6_pre_count", 32'(count_o), 32'd1);
    check("s6_pre_ferr", 32'(frame_err_o), 32'd1);
    pb = 8'hC3;
    n0 = cyc;
    win_q.push_back('{lo: n0 + 3, hi: n0 + 78});
    rx_i = 1'b0;
    tick(8);
    for (int k = 0; k < 4; k++) begin
      rx_i = pb[k];
      tick(8);
    end
    rx_i = pb[4];
    tick(4);
    rst_ni = 1'b0;
    rx_i = 1'b1;
    tick(2);
    check_reset_vals("s6_rst");
    rst_ni = 1'b1;
    tick(4);
    send_byte(8'h5A, 1'b1);
    tick(2);
    check("s6_valid", 32'(valid_o), 32'd1);
    check("s6_data", 32'(data_o), 32'h5A);
    check("s6_count", 32'(count_o), 32'd1);
    drain_expect(8'h5A);
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
